// File: rtl/calib_rx_ctrl.sv
// calib_rx_ctrl: receive-side calibration sequencer.
// Hunts for the sync word by issuing bit-slip requests, confirms lock over
// several consecutive sync words, then enables the 9b/8b decoder for the
// payload and checks each decoded byte against an incrementing reference.
module calib_rx_ctrl #(
  parameter logic [8:0]  SYNC_CODE     = 9'h166,
  parameter int unsigned HUNT_WORDS    = 16,
  parameter int unsigned SYNC_REPEAT   = 4,
  parameter int unsigned PAYLOAD_WORDS = 256,
  parameter int unsigned ERR_MAX       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       code_valid,
  input  logic [8:0] code_in,
  input  logic [7:0] dec_data,
  output logic       dec_enable,
  output logic       bit_slip,
  output logic       busy,
  output logic       locked,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [3:0] slip_cnt
);

  typedef enum logic [2:0] {
    IDLE, HUNT, LOCK_CHK, CHECK, DONE, FAIL
  } state_t;

  localparam logic [15:0] HUNT_LIM = 16'(HUNT_WORDS);
  localparam logic [15:0] SYNC_LIM = 16'(SYNC_REPEAT);
  localparam logic [15:0] PAY_LIM  = 16'(PAYLOAD_WORDS);
  // Nine slips walk the aligner through every bit phase of a 9-bit word.
  localparam logic [3:0]  SLIP_LIM = 4'd9;

  state_t      state;
  logic [15:0] miss_cnt;
  logic [15:0] sync_cnt;
  logic [15:0] en_cnt;     // payload words handed to the decoder
  logic [15:0] word_cnt;   // payload words compared
  logic [7:0]  expected;
  logic        cmp_pending;
  logic        is_sync;
  logic [7:0]  err_next;

  assign is_sync = code_valid && (code_in == SYNC_CODE);

  // NOTE: dec_enable must be combinational so the decoder captures the very
  // word presented this cycle; a registered enable would lag by one word.
  assign dec_enable = (state == CHECK) && code_valid && (en_cnt < PAY_LIM);

  // Saturating error count including the compare happening this cycle.
  assign err_next = ((dec_data != expected) && (err_cnt != 8'hFF))
                    ? err_cnt + 8'd1 : err_cnt;

  // Sequencer state, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_slip    <= 1'b0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_cnt     <= 8'd0;
      slip_cnt    <= 4'd0;
      miss_cnt    <= 16'd0;
      sync_cnt    <= 16'd0;
      en_cnt      <= 16'd0;
      word_cnt    <= 16'd0;
      expected    <= 8'd0;
      cmp_pending <= 1'b0;
    end else if (abort) begin
      // Abort wins over start; error and slip counts stay readable.
      state       <= IDLE;
      bit_slip    <= 1'b0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      cmp_pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in the
      // same cycle overrides these defaults without any read-after-write hazard.
      bit_slip    <= 1'b0;
      cmp_pending <= dec_enable;
      if (dec_enable) en_cnt <= en_cnt + 16'd1;

      unique case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            state    <= HUNT;
            busy     <= 1'b1;
            locked   <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 8'd0;
            slip_cnt <= 4'd0;
            miss_cnt <= 16'd0;
            sync_cnt <= 16'd0;
            en_cnt   <= 16'd0;
            word_cnt <= 16'd0;
            expected <= 8'd0;
          end
        end

        HUNT: begin
          if (code_valid) begin
            if (is_sync) begin
              miss_cnt <= 16'd0;
              if (SYNC_LIM == 16'd1) begin
                state  <= CHECK;
                locked <= 1'b1;
              end else begin
                state    <= LOCK_CHK;
                sync_cnt <= 16'd1;
              end
            end else if (miss_cnt + 16'd1 == HUNT_LIM) begin
              miss_cnt <= 16'd0;
              bit_slip <= 1'b1;
              slip_cnt <= slip_cnt + 4'd1;
              if (slip_cnt + 4'd1 == SLIP_LIM) begin
                state  <= FAIL;
                busy   <= 1'b0;
                done   <= 1'b1;
                pass   <= 1'b0;
                locked <= 1'b0;
              end
            end else begin
              miss_cnt <= miss_cnt + 16'd1;
            end
          end
        end

        LOCK_CHK: begin
          if (code_valid) begin
            if (is_sync) begin
              sync_cnt <= sync_cnt + 16'd1;
              if (sync_cnt + 16'd1 == SYNC_LIM) begin
                state  <= CHECK;
                locked <= 1'b1;
              end
            end else begin
              // A broken sync run restarts the hunt in the same phase.
              state    <= HUNT;
              miss_cnt <= 16'd0;
            end
          end
        end

        CHECK: begin
          if (cmp_pending) begin
            expected <= expected + 8'd1;
            word_cnt <= word_cnt + 16'd1;
            err_cnt  <= err_next;
            if (word_cnt + 16'd1 == PAY_LIM) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (32'(err_next) <= ERR_MAX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calib_rx_ctrl.sv
// Testbench for calib_rx_ctrl: table-driven sync/abort vectors, directed
// corner sequences, and randomized runs checked against a behavioural model
// of the aligner, decoder and payload checker.
module tb_calib_rx_ctrl;

  localparam logic [8:0] SYNC = 9'h166;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, code_valid;
  logic [8:0] code_in;
  logic [7:0] dec_data;

  logic       dec_enable, bit_slip, busy, locked, done, pass;
  logic [7:0] err_cnt;
  logic [3:0] slip_cnt;

  logic       dec_enable_b, bit_slip_b, busy_b, locked_b, done_b, pass_b;
  logic [7:0] err_cnt_b;
  logic [3:0] slip_cnt_b;

  calib_rx_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .code_valid(code_valid), .code_in(code_in), .dec_data(dec_data),
    .dec_enable(dec_enable), .bit_slip(bit_slip), .busy(busy),
    .locked(locked), .done(done), .pass(pass),
    .err_cnt(err_cnt), .slip_cnt(slip_cnt)
  );

  // Second instance tolerates three mismatches; it sees the same stream.
  calib_rx_ctrl #(.ERR_MAX(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .code_valid(code_valid), .code_in(code_in), .dec_data(dec_data),
    .dec_enable(dec_enable_b), .bit_slip(bit_slip_b), .busy(busy_b),
    .locked(locked_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_cnt_b), .slip_cnt(slip_cnt_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] pay [256];   // decoded payload bytes the decoder will deliver
  int         pay_idx;
  logic       last_en;

  typedef struct packed {
    logic       st;
    logic       ab;
    logic       cv;
    logic [8:0] code;
    logic       busy;
    logic       locked;
    logic       done;
    logic       bs;
    logic [3:0] slips;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One clock: sample the decoder enable before the edge, then model the
  // decoder's registered output appearing just after the edge.
  task automatic tick();
    #2;
    last_en = dec_enable;
    @(posedge clk);
    #1;
    if (last_en) begin
      dec_data = pay[pay_idx[7:0]];
      pay_idx++;
    end
  endtask

  function automatic logic [8:0] rand_nonsync();
    logic [8:0] w;
    w = 9'($urandom_range(511));
    if (w == SYNC) w = 9'h0FF;
    return w;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < 256; i++) pay[i] = 8'(i);
  endtask

  // Full calibration run. phase = slips the aligner needs before it delivers
  // aligned sync words (>8 means sync never appears).
  task automatic run(input string tag, input int phase, input int gap_pct);
    int   remaining, misses, slips, syncs, guard, exp_err;
    logic prev_bs;
    exp_err = 0;
    for (int i = 0; i < 256; i++) if (pay[i] != 8'(i)) exp_err++;
    if (exp_err > 255) exp_err = 255;

    pay_idx = 0;
    abort = 1'b0; code_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;

    remaining = phase; misses = 0; slips = 0; syncs = 0; guard = 0;
    prev_bs = 1'b0;
    while (!locked && !done && guard < 4000) begin
      code_valid = ($urandom_range(99) >= 32'(gap_pct));
      code_in    = (remaining == 0) ? SYNC : rand_nonsync();
      if (code_valid && remaining == 0) syncs++;
      if (code_valid && remaining != 0) misses++;
      tick();
      guard++;
      if (bit_slip) begin
        check({tag, "_slip_one_cycle"}, 32'(prev_bs), 32'd0);
        check({tag, "_misses_per_slip"}, 32'(misses), 32'd16);
        misses = 0;
        slips++;
        if (remaining > 0) remaining--;
      end
      prev_bs = bit_slip;
    end
    code_valid = 1'b0;
    check({tag, "_hunt_bound"}, 32'(guard < 4000), 32'd1);

    if (phase > 8) begin
      check({tag, "_fail_done"},   32'(done),     32'd1);
      check({tag, "_fail_pass"},   32'(pass),     32'd0);
      check({tag, "_fail_locked"}, 32'(locked),   32'd0);
      check({tag, "_fail_busy"},   32'(busy),     32'd0);
      check({tag, "_fail_slipcnt"}, 32'(slip_cnt), 32'd9);
      check({tag, "_fail_pulses"}, 32'(slips),    32'd9);
      repeat (40) begin
        code_valid = 1'b1;
        code_in    = rand_nonsync();
        tick();
        if (bit_slip) slips++;
      end
      code_valid = 1'b0;
      check({tag, "_no_tenth_slip"}, 32'(slips), 32'd9);
      check({tag, "_b_status"}, 32'({done_b, pass_b, locked_b, busy_b, slip_cnt_b}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 4'd9}));
      return;
    end

    check({tag, "_locked"},      32'(locked),   32'd1);
    check({tag, "_syncs_to_lock"}, 32'(syncs),  32'd4);
    check({tag, "_slip_pulses"}, 32'(slips),    32'(phase));
    check({tag, "_slip_cnt"},    32'(slip_cnt), 32'(phase));

    guard = 0;
    while (pay_idx < 256 && guard < 4000) begin
      code_valid = ($urandom_range(99) >= 32'(gap_pct));
      code_in    = rand_nonsync();
      tick();
      guard++;
    end
    check({tag, "_payload_bound"}, 32'(guard < 4000), 32'd1);

    // One cycle after the last accepted word: still checking, no new accept.
    check({tag, "_done_not_yet"}, 32'(done), 32'd0);
    code_valid = 1'b1;
    code_in    = rand_nonsync();
    #1;
    check({tag, "_accept_stops"}, 32'({dec_enable, dec_enable_b}), 32'd0);
    tick();
    code_valid = 1'b0;
    check({tag, "_done"},    32'(done),    32'd1);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_pass"},    32'(pass),    32'(exp_err == 0));
    check({tag, "_pass_b"},  32'(pass_b),  32'(exp_err <= 3));
    check({tag, "_err_cnt_b"}, 32'(err_cnt_b), 32'(exp_err));
    check({tag, "_b_status"}, 32'({done_b, locked_b, busy_b, bit_slip_b, slip_cnt_b}),
          32'({1'b1, 1'b1, 1'b0, 1'b0, 4'(phase)}));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; code_valid = 1'b0;
    code_in = 9'h000; dec_data = 8'h00; pay_idx = 0;
    fill_ramp();

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    tick();
    code_valid = 1'b1;
    #1;
    check("rst_status", 32'({busy, locked, done, pass, bit_slip, dec_enable}), 32'd0);
    check("rst_err_cnt",  32'(err_cnt),  32'd0);
    check("rst_slip_cnt", 32'(slip_cnt), 32'd0);
    code_valid = 1'b0;

    // Table: broken sync run returns to HUNT without a slip, lock on the
    // second run, then abort-with-start, restart and abort again.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, SYNC,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, SYNC,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, SYNC,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[5]  = '{1'b0, 1'b0, 1'b1, SYNC,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[6]  = '{1'b0, 1'b0, 1'b1, SYNC,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, SYNC,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, SYNC,   1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    vt[9]  = '{1'b1, 1'b1, 1'b1, SYNC,   1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    for (int i = 0; i < 12; i++) begin
      start = vt[i].st; abort = vt[i].ab;
      code_valid = vt[i].cv; code_in = vt[i].code;
      tick();
      check($sformatf("vec%0d", i), 32'({busy, locked, done, bit_slip, slip_cnt}),
            32'({vt[i].busy, vt[i].locked, vt[i].done, vt[i].bs, vt[i].slips}));
    end
    start = 1'b0; abort = 1'b0; code_valid = 1'b0;

    // Aligned, dense, clean payload.
    fill_ramp();
    run("aligned", 0, 0);

    // Misaligned by three phases, sparse valids.
    fill_ramp();
    run("phase3", 3, 30);

    // Corrupted bytes 5, 100 and 255 (the last compare counts).
    fill_ramp();
    pay[5] = 8'hAA; pay[100] = 8'h00; pay[255] = 8'h00;
    run("corrupt3", 0, 0);

    // Every byte wrong: counter saturates.
    for (int i = 0; i < 256; i++) pay[i] = ~8'(i);
    run("saturate", 1, 10);

    // Randomized runs against the model.
    for (int r = 0; r < 4; r++) begin
      int n;
      fill_ramp();
      n = int'($urandom_range(6));
      for (int k = 0; k < n; k++)
        pay[$urandom_range(255)] ^= 8'(1 + $urandom_range(254));
      run($sformatf("rand%0d", r), int'($urandom_range(8)), int'($urandom_range(50)));
    end

    // Sync word never appears.
    fill_ramp();
    run("nosync", 99, 0);

    // Abort mid-CHECK with start in the same cycle.
    fill_ramp();
    pay[2] = 8'hEE;
    pay_idx = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    code_valid = 1'b1; code_in = SYNC;
    repeat (4) tick();
    check("abort_pre_locked", 32'(locked), 32'd1);
    code_in = 9'h011;
    repeat (10) tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_status", 32'({busy, locked, done, pass}), 32'd0);
    check("abort_err_held", 32'(err_cnt), 32'd1);
    check("abort_slip_held", 32'(slip_cnt), 32'd0);
    #1;
    check("abort_dec_enable", 32'(dec_enable), 32'd0);
    tick();
    code_valid = 1'b0;
    check("abort_start_ignored", 32'(busy), 32'd0);
    fill_ramp();
    run("rerun", 0, 20);

    // Reset mid-HUNT after one slip.
    start = 1'b1;
    tick();
    start = 1'b0;
    code_valid = 1'b1;
    repeat (20) begin
      code_in = rand_nonsync();
      tick();
    end
    check("hunt_pre_slip_cnt", 32'(slip_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_status", 32'({busy, locked, done, pass, bit_slip, dec_enable}), 32'd0);
    check("midrst_counts", 32'({err_cnt, slip_cnt}), 32'd0);
    code_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
